// File: rtl/cia_arb_pkg.sv
// Shared types and constants for the CIA register-port arbiter.
// Holds the slot state encoding, idle bus values and starvation limit bounds.
package cia_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_SLOT = 2'd1,
        AUX_SLOT = 2'd2
    } slot_t;

    localparam logic       IDLE_CS_N = 1'b1;
    localparam logic       IDLE_RW   = 1'b1;
    localparam logic [3:0] IDLE_RS   = 4'h0;
    localparam logic [7:0] IDLE_DB   = 8'h00;

    localparam int unsigned STARVE_LIMIT_MIN = 1;
    localparam int unsigned STARVE_LIMIT_MAX = 15;

    // Keeps an out-of-range limit inside what the 4-bit streak counter can reach.
    function automatic logic [3:0] clamp_limit(input int unsigned limit);
        if (limit < STARVE_LIMIT_MIN) begin
            return 4'(STARVE_LIMIT_MIN);
        end else if (limit > STARVE_LIMIT_MAX) begin
            return 4'(STARVE_LIMIT_MAX);
        end else begin
            return 4'(limit);
        end
    endfunction

endpackage

// File: rtl/cia_bus_arbiter_starve.sv
// Starvation guard: counts CPU-won slots while aux waits and forces the aux side in.
// Only instantiated when CIA_ARB_STARVE_EN is defined.
module cia_arb_starve
    import cia_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic res_n,
    input  logic phi2_p,
    input  logic aux_req,
    input  logic cpu_cs_n,
    input  logic grant_cpu,
    input  logic grant_aux,
    output logic force_aux,
    output logic cpu_rdy
);

    localparam logic [3:0] LIMIT = clamp_limit(STARVE_LIMIT);

    logic [3:0] streak_reg;
    logic [3:0] streak_next;
    logic       cpu_rdy_reg;
    logic       cpu_rdy_next;

    assign force_aux = (streak_reg == LIMIT);
    assign cpu_rdy   = cpu_rdy_reg;

    always_comb begin
        streak_next  = streak_reg;
        cpu_rdy_next = cpu_rdy_reg;
        if (phi2_p) begin
            // A selected CPU that loses the slot can only have lost it to the guard.
            cpu_rdy_next = !(grant_aux && !cpu_cs_n);
            if (grant_aux || !aux_req) begin
                streak_next = 4'd0;
            end else if (grant_cpu && (streak_reg != 4'hF)) begin
                streak_next = streak_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            streak_reg  <= 4'd0;
            cpu_rdy_reg <= 1'b1;
        end else begin
            streak_reg  <= streak_next;
            cpu_rdy_reg <= cpu_rdy_next;
        end
    end

endmodule

// File: rtl/cia_bus_arbiter.sv
// Shares one CIA register port between the CPU (priority) and an aux requester, one access per Phi2 cycle.
// Define CIA_ARB_STARVE_EN to enable the starvation guard that stalls the CPU via cpu_rdy.
module cia_bus_arbiter
    import cia_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       phi2_p,
    input  logic       phi2_n,
    input  logic       cpu_cs_n,
    input  logic       cpu_rw,
    input  logic [3:0] cpu_rs,
    input  logic [7:0] cpu_db_in,
    output logic [7:0] cpu_db_out,
    output logic       cpu_rdy,
    input  logic       aux_req,
    input  logic       aux_we,
    input  logic [3:0] aux_addr,
    input  logic [7:0] aux_wdata,
    output logic       aux_ack,
    output logic [7:0] aux_rdata,
    output logic       cia_cs_n,
    output logic       cia_rw,
    output logic [3:0] cia_rs,
    output logic [7:0] cia_db_in,
    input  logic [7:0] cia_db_out
);

    slot_t      state_reg;
    slot_t      state_next;
    slot_t      win;
    logic       force_aux;
    logic       cap_reg;
    logic       bus_cs_n_reg;
    logic       bus_rw_reg;
    logic [3:0] bus_rs_reg;
    logic [7:0] bus_db_reg;
    logic [7:0] cpu_db_out_reg;
    logic [7:0] aux_rdata_reg;
    logic       cpu_cap;
    logic       aux_cap;

`ifdef CIA_ARB_STARVE_EN
    cia_arb_starve #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .res_n     (res_n),
        .phi2_p    (phi2_p),
        .aux_req   (aux_req),
        .cpu_cs_n  (cpu_cs_n),
        .grant_cpu (win == CPU_SLOT),
        .grant_aux (win == AUX_SLOT),
        .force_aux (force_aux),
        .cpu_rdy   (cpu_rdy)
    );
`else
    assign force_aux = 1'b0;
    assign cpu_rdy   = 1'b1;
`endif

    // Next-state: the winner is only adopted in a phi2_p cycle.
    always_comb begin
        win = IDLE;
        if (force_aux && aux_req) begin
            win = AUX_SLOT;
        end else if (!cpu_cs_n) begin
            win = CPU_SLOT;
        end else if (aux_req) begin
            win = AUX_SLOT;
        end
        state_next = phi2_p ? win : state_reg;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Bus outputs are loaded alongside the decision and held for the whole Phi2 cycle.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            bus_cs_n_reg <= IDLE_CS_N;
            bus_rw_reg   <= IDLE_RW;
            bus_rs_reg   <= IDLE_RS;
            bus_db_reg   <= IDLE_DB;
        end else if (phi2_p) begin
            case (win)
                CPU_SLOT: begin
                    bus_cs_n_reg <= 1'b0;
                    bus_rw_reg   <= cpu_rw;
                    bus_rs_reg   <= cpu_rs;
                    bus_db_reg   <= cpu_db_in;
                end
                AUX_SLOT: begin
                    bus_cs_n_reg <= 1'b0;
                    bus_rw_reg   <= !aux_we;
                    bus_rs_reg   <= aux_addr;
                    bus_db_reg   <= aux_wdata;
                end
                default: begin
                    bus_cs_n_reg <= IDLE_CS_N;
                    bus_rw_reg   <= IDLE_RW;
                    bus_rs_reg   <= IDLE_RS;
                    bus_db_reg   <= IDLE_DB;
                end
            endcase
        end
    end

    // The CIA presents read data one clk after phi2_n, so capture lags phi2_n by one.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cap_reg        <= 1'b0;
            cpu_db_out_reg <= 8'h00;
            aux_rdata_reg  <= 8'h00;
        end else begin
            cap_reg <= phi2_n;
            if (cpu_cap) begin
                cpu_db_out_reg <= cia_db_out;
            end
            if (aux_cap && bus_rw_reg) begin
                aux_rdata_reg <= cia_db_out;
            end
        end
    end

    // Output logic: ack and read data are valid during the capture cycle itself.
    always_comb begin
        cpu_cap   = cap_reg && (state_reg == CPU_SLOT) && bus_rw_reg;
        aux_cap   = cap_reg && (state_reg == AUX_SLOT);
        aux_ack   = aux_cap;
        aux_rdata = (aux_cap && bus_rw_reg) ? cia_db_out : aux_rdata_reg;
    end

    assign cpu_db_out = cpu_db_out_reg;
    assign cia_cs_n   = bus_cs_n_reg;
    assign cia_rw     = bus_rw_reg;
    assign cia_rs     = bus_rs_reg;
    assign cia_db_in  = bus_db_reg;

endmodule
